// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM demultiplexer.
// Slot count, slot-address width, lock/loss counter width and FSM state encoding.
package tdm_pkg;

    localparam int NSLOTS = 4;
    localparam int SLOT_W = 2;
    localparam int CNT_W  = 4;

    typedef logic [SLOT_W-1:0] slotAddr_t;
    typedef logic [CNT_W-1:0]  frameCnt_t;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } demuxState_t;

    // Slot addresses wrap naturally at NSLOTS because SLOT_W bits cover exactly four slots.
    function automatic slotAddr_t nextSlot(input slotAddr_t cur);
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/tdm_demux4_slot_counter.sv
// Mod-4 slot address counter with enable and synchronous load-to-value.
// A load request takes priority over the increment enable.
module slot_counter
    import tdm_pkg::*;
(
    input  logic      clk,
    input  logic      rstN,
    input  logic      en,
    input  logic      load,
    input  slotAddr_t loadVal,
    output slotAddr_t addr
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            addr <= '0;
        end else if (load) begin
            addr <= loadVal;
        end else if (en) begin
            addr <= nextSlot(addr);
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with frame-sync lock FSM; presents one parallel word per frame.
// Define DEMUX_INVERT_EN when the line driver is inverting (d = ~notD); default is d = notD.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int FRAMES_TO_LOCK = 2,
    parameter int FRAMES_TO_LOSE = 2
) (
    input  logic        CLK,
    input  logic        notRST,
    input  logic        notD,
    input  logic        EN,
    input  logic        FS,
    output logic [1:0]  A,
    output logic [3:0]  Q,
    output logic        VALID,
    output logic        LOCKED,
    output logic        ERR,
    output demuxState_t dbgState
);

    // Handshake: there is no back-pressure. EN=1 qualifies notD/FS for exactly one slot on
    // that rising edge; VALID is a one-cycle pulse that Q holds a fresh complete frame.

    demuxState_t          state, stateNext;
    frameCnt_t            good, goodNext, goodInc;
    frameCnt_t            miss, missNext, missInc;
    logic [NSLOTS-1:0]    shadow, shadowNext, qNext;
    logic                 validNext, errNext;
    logic                 cntEn, cntLoad;
    slotAddr_t            loadVal;
    logic                 d, hit, markerMiss;

`ifdef DEMUX_INVERT_EN
    assign d = ~notD;
`else
    assign d = notD;
`endif

    assign hit        = FS && (A == '0);
    assign markerMiss = (FS && (A != '0)) || (!FS && (A == '0));
    assign goodInc    = good + 1'b1;
    assign missInc    = miss + 1'b1;

    slot_counter u_slotCounter (
        .clk     (CLK),
        .rstN    (notRST),
        .en      (cntEn),
        .load    (cntLoad),
        .loadVal (loadVal),
        .addr    (A)
    );

    always_ff @(posedge CLK or negedge notRST) begin
        if (!notRST) begin
            state  <= HUNT;
            good   <= '0;
            miss   <= '0;
            shadow <= '0;
            Q      <= '0;
            VALID  <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= stateNext;
            good   <= goodNext;
            miss   <= missNext;
            shadow <= shadowNext;
            Q      <= qNext;
            VALID  <= validNext;
            ERR    <= errNext;
        end
    end

    always_comb begin
        stateNext  = state;
        goodNext   = good;
        missNext   = miss;
        shadowNext = shadow;
        qNext      = Q;
        validNext  = 1'b0;
        errNext    = ERR;
        cntEn      = 1'b0;
        cntLoad    = 1'b0;
        loadVal    = '0;
        if (EN) begin
            case (state)
                HUNT: begin
                    if (FS) begin
                        shadowNext[0] = d;
                        cntLoad       = 1'b1;
                        loadVal       = SLOT_W'(1);
                        goodNext      = CNT_W'(1);
                        if (FRAMES_TO_LOCK == 1) begin
                            stateNext = LOCK;
                            missNext  = '0;
                        end else begin
                            stateNext = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (FS && (A != '0)) begin
                        // Marker seen in the wrong slot: treat it as the true slot 0.
                        shadowNext[0] = d;
                        cntLoad       = 1'b1;
                        loadVal       = SLOT_W'(1);
                        goodNext      = CNT_W'(1);
                    end else if (!FS && (A == '0)) begin
                        stateNext = HUNT;
                        cntLoad   = 1'b1;
                        loadVal   = '0;
                        goodNext  = '0;
                    end else begin
                        shadowNext[A] = d;
                        cntEn         = 1'b1;
                        if (hit) begin
                            goodNext = goodInc;
                            if (goodInc == CNT_W'(FRAMES_TO_LOCK)) begin
                                stateNext = LOCK;
                                missNext  = '0;
                            end
                        end
                    end
                end
                LOCK: begin
                    shadowNext[A] = d;
                    if (markerMiss && (missInc == CNT_W'(FRAMES_TO_LOSE))) begin
                        stateNext = HUNT;
                        cntLoad   = 1'b1;
                        loadVal   = '0;
                        goodNext  = '0;
                        missNext  = '0;
                        errNext   = 1'b1;
                    end else begin
                        cntEn = 1'b1;
                        if (hit) begin
                            missNext = '0;
                        end else if (markerMiss) begin
                            missNext = missInc;
                        end
                        // The slot-3 capture is part of the word released this edge.
                        if (A == SLOT_W'(NSLOTS - 1)) begin
                            qNext     = shadowNext;
                            validNext = 1'b1;
                        end
                    end
                end
                default: begin
                    stateNext = HUNT;
                    cntLoad   = 1'b1;
                    loadVal   = '0;
                end
            endcase
        end
    end

    assign LOCKED   = (state == LOCK);
    assign dbgState = state;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: per-scenario tasks plus a Q scoreboard fed at slot 3.
// Line polarity follows DEMUX_INVERT_EN so the same bench covers both builds.
module tb_tdm_demux4;
    import tdm_pkg::*;

    logic        CLK = 1'b0;
    logic        notRST;
    logic        notD;
    logic        EN;
    logic        FS;
    logic [1:0]  A;
    logic [3:0]  Q;
    logic        VALID;
    logic        LOCKED;
    logic        ERR;
    demuxState_t dbgState;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    logic [3:0] monExp;

    tdm_demux4 dut (
        .CLK      (CLK),
        .notRST   (notRST),
        .notD     (notD),
        .EN       (EN),
        .FS       (FS),
        .A        (A),
        .Q        (Q),
        .VALID    (VALID),
        .LOCKED   (LOCKED),
        .ERR      (ERR),
        .dbgState (dbgState)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    function automatic logic toLine(input logic dd);
`ifdef DEMUX_INVERT_EN
        return ~dd;
`else
        return dd;
`endif
    endfunction

    // scoreboard: every VALID pops one expected word
    always @(posedge CLK) begin
        #1;
        if (notRST && VALID) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_valid: got Q=%b with no word expected", Q);
            end else begin
                monExp = exp_q.pop_front();
                if (Q !== monExp) begin
                    failures++;
                    $display("FAIL sb_q: got Q=%b expected %b", Q, monExp);
                end
            end
        end
    end

    // driver tasks
    task automatic cyc(input logic en, input logic fs, input logic dd);
        @(negedge CLK);
        EN   = en;
        FS   = fs;
        notD = toLine(dd);
        @(posedge CLK);
        #1;
    endtask

    task automatic sendFrame(input int fsSlot, input logic [3:0] bits, input logic expValid,
                             input int maxGap, input logic expLock0);
        logic [1:0] aHeld;
        logic [3:0] qHeld;
        for (int s = 0; s < 4; s++) begin
            int gaps;
            gaps = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                aHeld = A;
                qHeld = Q;
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                checks++;
                if (A !== aHeld || Q !== qHeld || VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold: got A=%b Q=%b VALID=%b expected A=%b Q=%b VALID=0",
                             A, Q, VALID, aHeld, qHeld);
                end
            end
            if (s == 3 && expValid) exp_q.push_back(bits);
            cyc(1'b1, (s == fsSlot), bits[s]);
            checks++;
            if (VALID !== (s == 3 && expValid)) begin
                failures++;
                $display("FAIL valid_slot%0d: got VALID=%b expected %b", s, VALID, (s == 3 && expValid));
            end
            if (s == 0) begin
                checks++;
                if (LOCKED !== expLock0) begin
                    failures++;
                    $display("FAIL locked_after_slot0: got %b expected %b", LOCKED, expLock0);
                end
            end
        end
    endtask

    task automatic drainCheck(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_valid: got %0d words left expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // scenarios
    task automatic test_reset();
        notRST = 1'b0;
        EN = 1'b0; FS = 1'b0; notD = 1'b0;
        #1;
        checks++;
        if ({Q, A, VALID, LOCKED, ERR} !== 9'b0 || dbgState !== HUNT) begin
            failures++;
            $display("FAIL reset_async: got Q=%b A=%b V=%b L=%b E=%b st=%0d expected all 0, HUNT",
                     Q, A, VALID, LOCKED, ERR, dbgState);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if ({Q, A, VALID, LOCKED, ERR} !== 9'b0 || dbgState !== HUNT) begin
                failures++;
                $display("FAIL reset_hold: got Q=%b A=%b V=%b L=%b E=%b st=%0d expected all 0, HUNT",
                         Q, A, VALID, LOCKED, ERR, dbgState);
            end
        end
        @(negedge CLK);
        EN = 1'b0;
        notRST = 1'b1;
    endtask

    task automatic test_acquisition();
        sendFrame(0, 4'b0010, 1'b0, 0, 1'b0);
        checks++;
        if (dbgState !== CHECK || LOCKED !== 1'b0 || A !== 2'd0) begin
            failures++;
            $display("FAIL acq_frame1: got st=%0d L=%b A=%b expected CHECK, 0, 00", dbgState, LOCKED, A);
        end
        sendFrame(0, 4'b0010, 1'b1, 0, 1'b1);
        for (int f = 0; f < 3; f++) sendFrame(0, 4'($urandom_range(0, 15)), 1'b1, 0, 1'b1);
        drainCheck("acq");
    endtask

    task automatic test_back_to_back();
        sendFrame(0, 4'b1111, 1'b1, 0, 1'b1);
        sendFrame(0, 4'b0000, 1'b1, 0, 1'b1);
        sendFrame(0, 4'b1001, 1'b1, 0, 1'b1);
        sendFrame(0, 4'b0110, 1'b1, 0, 1'b1);
        drainCheck("b2b");
    endtask

    task automatic test_stall();
        for (int f = 0; f < 5; f++) sendFrame(0, 4'($urandom_range(0, 15)), 1'b1, 3, 1'b1);
        drainCheck("stall");
    endtask

    task automatic test_loss_of_lock();
        sendFrame(-1, 4'b1010, 1'b1, 0, 1'b1);
        sendFrame(-1, 4'b0101, 1'b0, 0, 1'b0);
        checks++;
        if (dbgState !== HUNT || LOCKED !== 1'b0 || ERR !== 1'b1 || A !== 2'd0) begin
            failures++;
            $display("FAIL loss_drop: got st=%0d L=%b E=%b A=%b expected HUNT, 0, 1, 00",
                     dbgState, LOCKED, ERR, A);
        end
        sendFrame(0, 4'b0011, 1'b0, 1, 1'b0);
        sendFrame(0, 4'b1100, 1'b1, 1, 1'b1);
        checks++;
        if (ERR !== 1'b1 || LOCKED !== 1'b1) begin
            failures++;
            $display("FAIL loss_relock: got E=%b L=%b expected 1, 1", ERR, LOCKED);
        end
        drainCheck("loss");
    endtask

    task automatic test_misplaced_fs();
        @(negedge CLK);
        notRST = 1'b0;
        #1;
        checks++;
        if (ERR !== 1'b0 || dbgState !== HUNT) begin
            failures++;
            $display("FAIL misp_reset: got E=%b st=%0d expected 0, HUNT", ERR, dbgState);
        end
        @(negedge CLK);
        EN = 1'b0;
        notRST = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (A !== 2'd1 || dbgState !== CHECK) begin
            failures++;
            $display("FAIL misp_realign: got A=%b st=%0d expected 01, CHECK", A, dbgState);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            checks++;
            if (LOCKED !== 1'b0 || VALID !== 1'b0) begin
                failures++;
                $display("FAIL misp_nolock: got L=%b V=%b expected 0, 0", LOCKED, VALID);
            end
        end
        sendFrame(0, 4'b1101, 1'b1, 0, 1'b1);
        drainCheck("misp");
    endtask

    task automatic test_mid_frame_reset();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if (A !== 2'd2 || LOCKED !== 1'b1 || Q !== 4'b1101) begin
            failures++;
            $display("FAIL mid_pre: got A=%b L=%b Q=%b expected 10, 1, 1101", A, LOCKED, Q);
        end
        @(negedge CLK);
        #2;
        notRST = 1'b0;
        #1;
        checks++;
        if ({Q, A, VALID, LOCKED, ERR} !== 9'b0 || dbgState !== HUNT) begin
            failures++;
            $display("FAIL mid_reset: got Q=%b A=%b V=%b L=%b E=%b st=%0d expected all 0, HUNT",
                     Q, A, VALID, LOCKED, ERR, dbgState);
        end
        @(negedge CLK);
        EN = 1'b0;
        notRST = 1'b1;
        sendFrame(0, 4'b0111, 1'b0, 0, 1'b0);
        sendFrame(0, 4'b1011, 1'b1, 0, 1'b1);
        drainCheck("mid");
    endtask

    initial begin
        test_reset();
        test_acquisition();
        test_back_to_back();
        test_stall();
        test_loss_of_lock();
        test_misplaced_fs();
        test_mid_frame_reset();
        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive end of the 4:1 multiplexed serial line. It takes the single inverted-polarity line driven by the team's 4:1 mux, together with a slot strobe and a frame-sync marker. It tracks slot position with a 2-bit address counter and acquires frame lock through a small state machine. Once per frame it presents the four recovered channel bits in parallel, with a one-cycle valid strobe.

## Interface
- FRAMES_TO_LOCK, default 2, consecutive correctly placed FS markers required to enter LOCK (legal 1..15)
- FRAMES_TO_LOSE, default 2, consecutive missing or misplaced FS markers in LOCK that drop lock (legal 1..15)
- CLK  input  1  single clock; all state changes on rising edge
- notRST  input  1  asynchronous, active-low reset
- notD  input  1  serial line data, one slot per EN
- EN  input  1  slot strobe; notD/FS sampled only when EN=1
- FS  input  1  frame sync; high during slot 0
- A  output  2  address of the slot the next EN will sample (A1:A0 order)
- Q  output  4  recovered channel bits, Q[i] = slot i
- VALID  output  1  one-cycle pulse when Q updated
- LOCKED  output  1  high in LOCK state
- ERR  output  1  sticky; set on loss of lock

## Operation
- Recovered bit d = ~notD with DEMUX_INVERT_EN defined, else d = notD.
- Slot bits are captured into a 4-bit shadow register at index A. Q is loaded from the shadow only at frame completion, so all four bits change together.
- States: HUNT, CHECK, LOCK. Encoding comes from the package.
- HUNT:
  - EN with FS=0 is ignored; A holds 0.
  - EN with FS=1 captures d into slot 0, sets A=1 and good=1.
  - Next state is CHECK, or LOCK directly when FRAMES_TO_LOCK=1.
- CHECK/LOCK: each EN captures d into the shadow at A, then A increments mod 4 (3 wraps to 0).
- Marker check at each EN: "hit" = FS=1 with A=0. "miss" = FS=0 with A=0, or FS=1 with A≠0.
- CHECK:
  - A hit increments good; when good reaches FRAMES_TO_LOCK, go to LOCK and clear miss.
  - A miss with FS=1 at A≠0 realigns: capture as slot 0, A=1, good=1, stay in CHECK.
  - A miss with FS=0 at A=0 returns to HUNT with A=0.
- LOCK:
  - A hit clears miss.
  - A miss increments miss. When miss reaches FRAMES_TO_LOSE: go to HUNT, A=0, set ERR, no VALID for that frame.
  - A miss below the threshold keeps the counter free-running; no realign.
- VALID and the Q update occur only in LOCK, on the EN that captures slot 3 (A=3).
- The capture on that EN is included in Q. VALID is never asserted outside LOCK.
- ERR is cleared only by notRST.

## Timing
- Reset (async assert, output values immediate):
  - Q=0, A=0, VALID=0, LOCKED=0, ERR=0, state HUNT, good=0, miss=0, shadow=0.
- Reset deassertion is synchronised by the system. The first active edge after release may sample.
- Latency: for the slot-3 sampling edge (EN=1, A=3), Q and VALID are visible after that same edge, i.e. registered one clock after the sample is presented. VALID is high for exactly one CLK.
- A is registered and changes only on edges with EN=1, or on a transition into HUNT.
- LOCKED follows the registered state: it rises after the edge that completes lock and falls after the edge that drops it.
- EN=0 cycles stall everything: counters, state and outputs hold, and VALID=0.
- Back-to-back EN=1 is supported: one slot per clock, so one VALID every 4 clocks in steady LOCK.
- notRST asserted mid-frame discards the partial shadow immediately; Q returns to 0.

## Configuration
- DEMUX_INVERT_EN defined: input is treated as active-low (the mux drives inverted output); d = ~notD.
- DEMUX_INVERT_EN undefined: d = notD, for links with a non-inverting driver.
- No other behaviour changes.

## Structure
- Package tdm_pkg:
  - NSLOTS=4 and slot address width 2.
  - State encoding for HUNT/CHECK/LOCK.
  - Counter width for good/miss (4 bits).
- Sub-module slot_counter: the 2-bit mod-4 address counter with enable and synchronous load-to-value. It is instantiated once; the top handles the FSM, shadow and Q.

## Test plan
- Reset: hold notRST=0 with random inputs → Q=0000, A=00, VALID=0, LOCKED=0, ERR=0.
- Acquisition (defaults, invert on): continuous EN=1, FS in every 4th slot, notD slots = 1,0,1,1 (d=0,1,0,0).
  - LOCKED rises after the 2nd FS at slot 0.
  - First VALID at the end of that frame with Q=0010; VALID then every 4 clocks.
- Stall: insert EN=0 gaps of 1–3 cycles inside frames → A, Q, state held; same Q values; VALID only on slot-3 EN.
- Loss of lock: in LOCK, suppress FS for 2 consecutive frames → HUNT, LOCKED=0, ERR=1, no VALID for the 2nd bad frame. Resume FS → relock after 2 frames; ERR stays 1.
- Misplaced FS in CHECK: FS at slot 2 after the first marker → A reloads to 1, good=1, and lock occurs 1 frame later than nominal.
- Mid-frame reset: assert notRST while A=2 in LOCK → immediate reset values; reacquisition from HUNT.
